mem_stage: RTL

// Memory-access pipeline stage between EX and WB.
// - Consumes the registered EX->MEM bundle.
// - Issues one data-SRAM request per load/store over a req/addr_ok/data_ok handshake.
// - Aligns and extends load data, and registers the MEM->WB bundle.
// - Supplies a forwarding/stall view of the instruction it holds to ID.

---
 rtl/mem_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data-SRAM request per load/store,
// aligns/extends load data and registers the MEM->WB bundle.
module mem_stage #(
  parameter int EX2MEM_W = 145,
  parameter int MEM2WB_W = 103
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                WB_allowin,
  input  logic [EX2MEM_W-1:0] EX_to_MEM_zip,
  output logic                MEM_allowin,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [3:0]          data_sram_wstrb,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  output logic                front_valid,
  output logic                front_stall,
  output logic [4:0]          front_addr,
  output logic [31:0]         front_data,
  output logic [MEM2WB_W-1:0] MEM_to_WB_reg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic        valid;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
  logic        st_b, st_h, st_w;
  logic        mem_we, res_from_mem, gr_we;
  logic [31:0] rkd_value;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;

  assign {valid, pc, ir, ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w,
          mem_we, res_from_mem, gr_we, rkd_value, rf_waddr, alu_result} = EX_to_MEM_zip;

  state_t      state, state_next;
  logic        latch_rdata;
  logic        req_q;
  logic [31:0] rdata_buf;
  logic        mem_op;
  logic        readygo;
  logic [1:0]  a;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign mem_op  = mem_we | res_from_mem;
  assign readygo = (state == S_DONE);
  assign a       = alu_result[1:0];

  // state register and registered request flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      req_q <= 1'b0;
    end else begin
      state <= state_next;
      req_q <= (state_next == S_REQ);
    end
  end

  // next-state logic for the request/response handshake
  always_comb begin
    state_next  = state;
    latch_rdata = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid) state_next = mem_op ? S_REQ : S_DONE;
        else       state_next = S_IDLE;
      end
      S_REQ: begin
        if (data_sram_addr_ok && data_sram_data_ok) begin
          state_next  = S_DONE;
          latch_rdata = 1'b1;
        end else if (data_sram_addr_ok) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          state_next  = S_DONE;
          latch_rdata = 1'b1;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DONE: begin
        if (WB_allowin) state_next = S_IDLE;
        else            state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // load-data capture; only responses seen in REQ/WAIT are taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_buf <= 32'd0;
    end else if (latch_rdata) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign data_sram_req  = req_q;
  assign data_sram_wr   = mem_we;
  assign data_sram_addr = alu_result;

  // store lane encoding; word stores ignore the low address bits
  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = rkd_value;
    if (st_b) begin
      data_sram_wstrb = 4'b0001 << a;
      data_sram_wdata = {4{rkd_value[7:0]}};
    end else if (st_h) begin
      data_sram_wstrb = a[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{rkd_value[15:0]}};
    end else if (st_w) begin
      data_sram_wstrb = 4'b1111;
      data_sram_wdata = rkd_value;
    end else begin
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = rkd_value;
    end
  end

  // load alignment and sign/zero extension
  always_comb begin
    load_byte = rdata_buf[{a, 3'b000} +: 8];
    load_half = rdata_buf[{a[1], 4'b0000} +: 16];
    load_val  = rdata_buf;
    if (ld_b)       load_val = {{24{load_byte[7]}}, load_byte};
    else if (ld_bu) load_val = {24'd0, load_byte};
    else if (ld_h)  load_val = {{16{load_half[15]}}, load_half};
    else if (ld_hu) load_val = {16'd0, load_half};
    else if (ld_w)  load_val = rdata_buf;
    else            load_val = rdata_buf;
  end

  assign final_result = res_from_mem ? load_val : alu_result;

  assign MEM_allowin = ~valid | (readygo & WB_allowin);
  assign front_valid = valid & gr_we;
  assign front_stall = valid & res_from_mem & (state != S_DONE);
  assign front_addr  = rf_waddr;
  assign front_data  = final_result;

  // MEM->WB bundle: commit when done, bubble when WB is free but we are not
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_to_WB_reg <= '0;
    end else if (WB_allowin) begin
      if (readygo) MEM_to_WB_reg <= {valid, pc, ir, gr_we, rf_waddr, final_result};
      else         MEM_to_WB_reg <= '0;
    end
  end

endmodule
